taxi_rgmii_idelay_cal: RTL
==========================

TAXI_RGMII_IDELAY_CAL -- requirements
Module: taxi_rgmii_idelay_cal

Interface
REQ-001 Parameter TAP_W, default 9, width of the IDELAYE3 CNTVALUEIN tap count.
REQ-002 Parameter TAP_STEP, default 16, tap increment between sweep points.
REQ-003 Parameter TAP_MAX, default 511, highest tap tested.
REQ-004 Parameter DEFAULT_TAP, default 0, tap loaded on calibration failure.
REQ-005 Parameter VTC_WAIT, default 16, cycles between EN_VTC deassert and first load.
REQ-006 Parameter SETTLE_CYCLES, default 64, cycles after each load before sampling.
REQ-007 Parameter DWELL_CYCLES, default 65536, sampling window per tap.
REQ-008 Parameter MIN_OK, default 4, good samples a tap needs to pass.
REQ-009 clk  input  1  system clock; one clock domain only.
REQ-010 rst_n  input  1  reset, asynchronous, active-low.
REQ-011 start  input  1  single-cycle request to begin calibration.
REQ-012 rx_sample_valid  input  1  one pulse per receive quality sample, e.g. frame end.
REQ-013 rx_sample_ok  input  1  qualifies rx_sample_valid: 1 good, 0 bad (CRC or ctl error).
REQ-014 dly_cnt  output  TAP_W  tap value driven to CNTVALUEIN.
REQ-015 dly_load  output  1  LOAD strobe to IDELAYE3.
REQ-016 dly_en_vtc  output  1  EN_VTC to IDELAYE3.
REQ-017 busy, done, fail  output  1 each  status flags.
REQ-018 eye_width  output  TAP_W+1  tap span of the chosen pass window.

Function
REQ-019 States: IDLE, VTC_OFF, LOAD, SETTLE, DWELL, EVAL, FINAL_LOAD, FINAL_SETTLE, VTC_ON.
REQ-020 IDLE->VTC_OFF on start=1; start while busy=1 is ignored.
REQ-021 VTC_OFF: dly_en_vtc=0 for VTC_WAIT cycles, then tap index=0 and go to LOAD.
REQ-022 LOAD: dly_cnt set to current tap one cycle before a single-cycle dly_load; dly_cnt held stable through that cycle; then SETTLE.
REQ-023 SETTLE: wait SETTLE_CYCLES; rx_sample inputs ignored; then DWELL.
REQ-024 DWELL: count ok samples (saturating at MIN_OK) and flag any bad sample over DWELL_CYCLES cycles.
REQ-025 A tap passes iff ok count >= MIN_OK and no bad sample; zero samples means fail.
REQ-026 EVAL tracks the contiguous pass run start/end. A run replaces the best run only if strictly longer, so ties keep the earliest run.
REQ-027 EVAL: if tap+TAP_STEP <= TAP_MAX, advance tap and go to LOAD; otherwise close any open run and go to FINAL_LOAD.
REQ-028 Final tap = floor((first_pass_tap + last_pass_tap)/2) of best run; eye_width = last-first+TAP_STEP.
REQ-029 No passing tap: final tap = DEFAULT_TAP, eye_width=0, fail=1.
REQ-030 FINAL_LOAD uses the same load protocol as REQ-022. FINAL_SETTLE waits SETTLE_CYCLES. VTC_ON then sets dly_en_vtc=1 and returns to IDLE.
REQ-031 busy=1 from the cycle after start through VTC_ON. done pulses one cycle on entry to IDLE after a run.
REQ-032 fail and eye_width hold until the next start, which clears them.
REQ-033 Tap arithmetic uses TAP_W+1 bits; tap never exceeds TAP_MAX (no wrap).
REQ-034 If rx_sample_valid coincides with the DWELL->EVAL transition, the sample is discarded.

Reset
REQ-035 rst_n=0 asynchronously forces IDLE, including mid-sweep.
REQ-036 Reset values: dly_cnt=DEFAULT_TAP, dly_load=0, dly_en_vtc=1, busy=0, done=0, fail=0, eye_width=0.
REQ-037 All counters and run registers clear on reset; no load is issued on reset exit.

Configuration
REQ-038 Macro TAXI_RGMII_IDELAY_CAL_AUTOSTART_EN, if defined: an internal one-shot start fires on the first clock after rst_n deasserts.
REQ-039 Macro undefined: calibration starts only from the start port, and the module stays in IDLE after reset.

Verification
REQ-040 TAP_STEP=32, TAP_MAX=511, passing taps 96..256 -> 16 loads (0..480), final dly_cnt=176, eye_width=192, fail=0, done pulse.
REQ-041 Pass runs 32..64 and 320..352 (equal length) -> final dly_cnt=48 (earliest run).
REQ-042 All samples bad -> fail=1, dly_cnt=DEFAULT_TAP, eye_width=0, dly_en_vtc returns to 1.
REQ-043 Pass run 448..480 reaching the sweep end -> run closed at end, final dly_cnt=464.
REQ-044 rst_n pulsed low mid-DWELL -> outputs at reset values immediately; a new start runs a full sweep from tap 0. A start pulse during busy does not restart the sweep.
REQ-045 Autostart macro defined, no start pulse -> sweep begins one cycle after reset release. Macro undefined -> stays in IDLE with busy=0.

Source files
------------

// File: rtl/taxi_rgmii_idelay_cal.sv
// -----------------------------------------------------------------------------
// taxi_rgmii_idelay_cal
//
// RGMII receive IDELAYE3 tap calibration. The block sweeps the delay tap from 0
// to TAP_MAX in TAP_STEP increments. At each tap it loads the IDELAY, waits for
// the line to settle, and then counts receive quality samples over a dwell
// window. The longest contiguous run of passing taps wins, with ties going to
// the earliest run. The tap at the centre of that run is loaded last. If no tap
// passes, DEFAULT_TAP is loaded instead and fail is raised.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             single-cycle calibration request (ignored while busy)
//   rx_sample_valid   one pulse per receive quality sample
//   rx_sample_ok      qualifies rx_sample_valid: 1 good, 0 bad
//   dly_cnt           tap value for IDELAYE3 CNTVALUEIN
//   dly_load          single-cycle LOAD strobe for IDELAYE3
//   dly_en_vtc        EN_VTC for IDELAYE3 (low while taps are being changed)
//   busy, done, fail  status; done pulses for one cycle when a run completes
//   eye_width         tap span of the chosen pass window (0 on failure)
//
// Build option
//   TAXI_RGMII_IDELAY_CAL_AUTOSTART_EN : when defined, a one-shot internal start
//   fires on the first clock after reset release.
// -----------------------------------------------------------------------------
module taxi_rgmii_idelay_cal #(
  parameter int TAP_W         = 9,
  parameter int TAP_STEP      = 16,
  parameter int TAP_MAX       = 511,
  parameter int DEFAULT_TAP   = 0,
  parameter int VTC_WAIT      = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int DWELL_CYCLES  = 65536,
  parameter int MIN_OK        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rx_sample_valid,
  input  logic             rx_sample_ok,
  output logic [TAP_W-1:0] dly_cnt,
  output logic             dly_load,
  output logic             dly_en_vtc,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [TAP_W:0]   eye_width
);

  localparam int OK_W = $clog2(MIN_OK + 2);
  localparam logic [TAP_W+1:0] STEP_X = (TAP_W+2)'(TAP_STEP);
  localparam logic [TAP_W+1:0] MAX_X  = (TAP_W+2)'(TAP_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_VTC_OFF, S_LOAD, S_SETTLE, S_DWELL, S_EVAL,
    S_FINAL_LOAD, S_FINAL_SETTLE, S_VTC_ON
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [TAP_W:0]    tap_q, tap_d;
  logic [OK_W-1:0]   ok_q, ok_d;
  logic              bad_q, bad_d;
  logic              run_open_q, run_open_d;
  logic [TAP_W:0]    run_start_q, run_start_d, run_end_q, run_end_d;
  logic              best_valid_q, best_valid_d;
  logic [TAP_W:0]    best_start_q, best_start_d, best_end_q, best_end_d;
  logic [TAP_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic              dly_load_q, dly_load_d;
  logic              en_vtc_q, en_vtc_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [TAP_W:0]    eye_q, eye_d;

  logic              start_eff;
  logic [TAP_W+1:0]  tap_sum;
  logic              last_tap;
  logic              tap_pass;
  logic              close_run;
  logic [TAP_W+1:0]  mid_sum;

`ifdef TAXI_RGMII_IDELAY_CAL_AUTOSTART_EN
  // Set by reset, consumed by the first clock edge after reset release.
  logic auto_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) auto_q <= 1'b1;
    else        auto_q <= 1'b0;
  end
  assign start_eff = start | auto_q;
`else
  assign start_eff = start;
`endif

  // The sum is one bit wider than the tap so the end-of-sweep test cannot wrap.
  assign tap_sum  = {1'b0, tap_q} + STEP_X;
  assign last_tap = (tap_sum > MAX_X);
  assign tap_pass = (ok_q >= OK_W'(MIN_OK)) && !bad_q;

  function automatic logic reached(input logic [31:0] c, input int unsigned n);
    return (c + 32'd1) >= n;
  endfunction

  always_comb begin
    // NOTE: every signal driven here is given a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + 32'd1;
    tap_d        = tap_q;
    ok_d         = ok_q;
    bad_d        = bad_q;
    run_open_d   = run_open_q;
    run_start_d  = run_start_q;
    run_end_d    = run_end_q;
    best_valid_d = best_valid_q;
    best_start_d = best_start_q;
    best_end_d   = best_end_q;
    dly_cnt_d    = dly_cnt_q;
    dly_load_d   = 1'b0;
    en_vtc_d     = en_vtc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
    eye_d        = eye_q;
    close_run    = 1'b0;
    mid_sum      = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_eff) begin
          state_d      = S_VTC_OFF;
          busy_d       = 1'b1;
          en_vtc_d     = 1'b0;
          fail_d       = 1'b0;
          eye_d        = '0;
          run_open_d   = 1'b0;
          best_valid_d = 1'b0;
        end
      end
      S_VTC_OFF: begin
        if (reached(cnt_q, VTC_WAIT)) begin
          state_d   = S_LOAD;
          cnt_d     = '0;
          tap_d     = '0;
          dly_cnt_d = '0;
        end
      end
      // dly_cnt was updated on entry, so it is stable for a full cycle before
      // the LOAD strobe appears and stays stable while the strobe is high.
      S_LOAD: begin
        dly_load_d = 1'b1;
        state_d    = S_SETTLE;
        cnt_d      = '0;
      end
      S_SETTLE: begin
        if (reached(cnt_q, SETTLE_CYCLES)) begin
          state_d = S_DWELL;
          cnt_d   = '0;
          ok_d    = '0;
          bad_d   = 1'b0;
        end
      end
      // A sample arriving on the final dwell cycle is dropped.
      S_DWELL: begin
        if (reached(cnt_q, DWELL_CYCLES)) begin
          state_d = S_EVAL;
          cnt_d   = '0;
        end else if (rx_sample_valid) begin
          if (!rx_sample_ok)               bad_d = 1'b1;
          else if (ok_q < OK_W'(MIN_OK))   ok_d  = ok_q + OK_W'(1);
        end
      end
      S_EVAL: begin
        cnt_d = '0;
        if (tap_pass) begin
          if (!run_open_q) run_start_d = tap_q;
          run_open_d = 1'b1;
          run_end_d  = tap_q;
        end else if (run_open_q) begin
          close_run = 1'b1;
        end
        // The sweep is ending, so a run that is still open is closed here.
        if (last_tap && run_open_d) close_run = 1'b1;
        // A strictly longer run is required to replace the best, so ties keep
        // the earliest run.
        if (close_run) begin
          run_open_d = 1'b0;
          if (!best_valid_q ||
              ((run_end_d - run_start_d) > (best_end_q - best_start_q))) begin
            best_valid_d = 1'b1;
            best_start_d = run_start_d;
            best_end_d   = run_end_d;
          end
        end
        if (!last_tap) begin
          state_d   = S_LOAD;
          tap_d     = tap_sum[TAP_W:0];
          dly_cnt_d = tap_sum[TAP_W-1:0];
        end else begin
          state_d = S_FINAL_LOAD;
          mid_sum = {1'b0, best_start_d} + {1'b0, best_end_d};
          if (best_valid_d) begin
            dly_cnt_d = mid_sum[TAP_W:1];
            eye_d     = best_end_d - best_start_d + STEP_X[TAP_W:0];
            fail_d    = 1'b0;
          end else begin
            dly_cnt_d = TAP_W'(DEFAULT_TAP);
            eye_d     = '0;
            fail_d    = 1'b1;
          end
        end
      end
      S_FINAL_LOAD: begin
        dly_load_d = 1'b1;
        state_d    = S_FINAL_SETTLE;
        cnt_d      = '0;
      end
      S_FINAL_SETTLE: begin
        if (reached(cnt_q, SETTLE_CYCLES)) begin
          state_d = S_VTC_ON;
          cnt_d   = '0;
        end
      end
      S_VTC_ON: begin
        en_vtc_d = 1'b1;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
        cnt_d    = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its next-state value from the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tap_q        <= '0;
      ok_q         <= '0;
      bad_q        <= 1'b0;
      run_open_q   <= 1'b0;
      run_start_q  <= '0;
      run_end_q    <= '0;
      best_valid_q <= 1'b0;
      best_start_q <= '0;
      best_end_q   <= '0;
      dly_cnt_q    <= TAP_W'(DEFAULT_TAP);
      dly_load_q   <= 1'b0;
      en_vtc_q     <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      eye_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tap_q        <= tap_d;
      ok_q         <= ok_d;
      bad_q        <= bad_d;
      run_open_q   <= run_open_d;
      run_start_q  <= run_start_d;
      run_end_q    <= run_end_d;
      best_valid_q <= best_valid_d;
      best_start_q <= best_start_d;
      best_end_q   <= best_end_d;
      dly_cnt_q    <= dly_cnt_d;
      dly_load_q   <= dly_load_d;
      en_vtc_q     <= en_vtc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      eye_q        <= eye_d;
    end
  end

  assign dly_cnt    = dly_cnt_q;
  assign dly_load   = dly_load_q;
  assign dly_en_vtc = en_vtc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign eye_width  = eye_q;

endmodule
